wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the execute-stage result interface: takes the EX write-back triple (data, destination index, write enable).
- Registers the triple in a write-back (WB) pipeline register, then commits it into the architectural register file.
- Provides two read ports for the decode stage, with forwarding from EX and WB so the decoder always sees the youngest value.

Parameters:
DATA_W, 32, register/data width in bits
ADDR_W, 5, register index width
NUM_REGS, 32, number of architectural registers (2**ADDR_W); register 0 reads as zero

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
stall_i  input  1  hold WB register and suppress commit this cycle
flush_i  input  1  invalidate incoming EX result
ex_wdata_i  input  DATA_W  EX result data
ex_wd_i  input  ADDR_W  EX destination register index
ex_wreg_i  input  1  EX result writes a register
re1_i  input  1  read port 1 enable
raddr1_i  input  ADDR_W  read port 1 index
re2_i  input  1  read port 2 enable
raddr2_i  input  ADDR_W  read port 2 index
rdata1_o  output  DATA_W  read port 1 data (combinational)
rdata2_o  output  DATA_W  read port 2 data (combinational)
wb_wdata_o  output  DATA_W  WB register data
wb_wd_o  output  ADDR_W  WB register destination
wb_wreg_o  output  1  WB register valid write
retire_cnt_o  output  32  count of committed non-zero-index writes

Behaviour:
- Reset (rst=0, asynchronous, any time): wb_wdata_o=0, wb_wd_o=0, wb_wreg_o=0, retire_cnt_o=0, all NUM_REGS registers=0. Read outputs follow combinationally from this state.
- Reset mid-stream discards the WB content; no commit occurs on the edge coincident with reset release.
- WB register update at each rising clk, with rst=1, in priority order:
  - flush_i=1 (wins over stall): wb_wreg_o<=0; wb_wd_o and wb_wdata_o <= 0.
  - else stall_i=1: hold all WB fields.
  - else: capture ex_wdata_i, ex_wd_i, ex_wreg_i.
- Commit: on a rising clk where wb_wreg_o=1, stall_i=0 and wb_wd_o!=0:
  - regs[wb_wd_o] <= wb_wdata_o.
  - retire_cnt_o increments by 1.
- Commit is based on the WB content before the edge. Net latency: EX result visible in the array 2 edges after being presented.
- A stalled WB entry commits exactly once, on the first unstalled edge. Stall never double-counts.
- Flush does not cancel the commit of the entry already in WB on that same edge.
- Writes with index 0 are dropped and not counted. retire_cnt_o wraps 0xFFFFFFFF -> 0.
- Read port n, combinational, first matching rule wins:
  1. re=0 -> 0.
  2. raddr=0 -> 0.
  3. ex_wreg_i=1 and ex_wd_i==raddr and flush_i=0 -> ex_wdata_i.
  4. wb_wreg_o=1 and wb_wd_o==raddr -> wb_wdata_o.
  5. Otherwise regs[raddr].
- Both ports are independent; the same index may be read on both ports simultaneously.
- Rule 4 applies regardless of stall_i, because a pending WB value is architecturally younger than the array.
- The array has no combinational path from clk; read data must settle within the same cycle as the address.

Test Plan:
- Reset then read: rst=0->1, re1=1 raddr1=5 -> rdata1=0, retire_cnt=0, wb_wreg=0.
- Basic write: EX presents (wd=3, data=0x12345678, wreg=1) for one cycle. After edge 1, wb_wd=3. After edge 2, EX idle, read raddr1=3 gives 0x12345678 and retire_cnt=1.
- Forwarding priority: regs[7]=0x1, WB holds (7, 0x2), EX presents (7, 0x3). rdata1 (raddr 7) = 0x3. With ex_wreg=0, rdata1 = 0x2. After commit with EX idle, rdata1 = 0x2.
- Register zero: EX writes (0, 0xFFFFFFFF). Read raddr=0 gives 0 in every cycle, and retire_cnt is unchanged.
- Stall/flush: WB holds (4, 0xAA) with stall=1 for 3 cycles, so no commit and retire_cnt is constant. Release stall with flush=1 on the same edge: regs[4]=0xAA, retire_cnt+1, wb_wreg=0 after the edge, and EX's (9, 0xBB) is never written.
- Async reset mid-operation: WB holds (6, 0x55), assert rst=0 between edges. Outputs clear immediately, regs[6] stays 0 after release, and retire_cnt=0.

Source files
------------

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//
// Write-back stage and architectural register file. The execute-stage result
// (data, destination index, write enable) is captured in a WB pipeline
// register and committed into the register array on the following edge.
// Two read ports serve the decode stage. Each port forwards from EX and from
// WB so that decode always sees the youngest value of a register.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-low
//   stall_i       hold the WB register and suppress commit this cycle
//   flush_i       invalidate the incoming EX result
//   ex_wdata_i    EX result data
//   ex_wd_i       EX destination register index
//   ex_wreg_i     EX result writes a register
//   re1_i         read port 1 enable
//   raddr1_i      read port 1 index
//   re2_i         read port 2 enable
//   raddr2_i      read port 2 index
//   rdata1_o      read port 1 data (combinational)
//   rdata2_o      read port 2 data (combinational)
//   wb_wdata_o    WB register data
//   wb_wd_o       WB register destination
//   wb_wreg_o     WB register holds a valid write
//   retire_cnt_o  count of committed writes to non-zero registers
// ---------------------------------------------------------------------------
module wb_regfile #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] ex_wdata_i,
   input  logic [ADDR_W-1:0] ex_wd_i,
   input  logic              ex_wreg_i,
   input  logic              re1_i,
   input  logic [ADDR_W-1:0] raddr1_i,
   input  logic              re2_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [DATA_W-1:0] rdata2_o,
   output logic [DATA_W-1:0] wb_wdata_o,
   output logic [ADDR_W-1:0] wb_wd_o,
   output logic              wb_wreg_o,
   output logic [31:0]       retire_cnt_o
);

   logic [DATA_W-1:0] wbWdata_q, wbWdata_d;
   logic [ADDR_W-1:0] wbWd_q,    wbWd_d;
   logic              wbWreg_q,  wbWreg_d;
   logic [31:0]       retireCnt_q, retireCnt_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic              commitEn;

   // A commit uses the WB content held before the edge. Stall defers it so a
   // held entry is written exactly once, on its first unstalled edge. Flush
   // only affects what enters WB, so it never cancels this commit. Writes to
   // register zero are dropped and not counted.
   assign commitEn = wbWreg_q && !stall_i && (wbWd_q != '0);

   // Next WB content: flush beats stall, stall holds, otherwise take EX.
   always_comb begin
      wbWdata_d = wbWdata_q;
      wbWd_d    = wbWd_q;
      wbWreg_d  = wbWreg_q;
      if (flush_i) begin
         wbWdata_d = '0;
         wbWd_d    = '0;
         wbWreg_d  = 1'b0;
      end else if (!stall_i) begin
         wbWdata_d = ex_wdata_i;
         wbWd_d    = ex_wd_i;
         wbWreg_d  = ex_wreg_i;
      end
   end

   // Retire counter advances once per real commit and wraps naturally.
   always_comb begin
      retireCnt_d = retireCnt_q;
      if (commitEn) begin
         retireCnt_d = retireCnt_q + 32'd1;
      end
   end

   // WB pipeline register and retire counter. Reset discards any pending WB
   // entry, so nothing in flight is committed across a reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wbWdata_q   <= '0;
         wbWd_q      <= '0;
         wbWreg_q    <= 1'b0;
         retireCnt_q <= '0;
      end else begin
         wbWdata_q   <= wbWdata_d;
         wbWd_q      <= wbWd_d;
         wbWreg_q    <= wbWreg_d;
         retireCnt_q <= retireCnt_d;
      end
   end

   // Architectural register array. Entry zero is never written, so it stays
   // zero, though the read ports also force it to zero independently.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (commitEn) begin
         regs_q[wbWd_q] <= wbWdata_q;
      end
   end

   // Read port 1. EX is the youngest producer, so it is checked first unless
   // it is being flushed. A pending WB entry is younger than the array and is
   // forwarded even while stalled.
   always_comb begin
      rdata1_o = regs_q[raddr1_i];
      if (!re1_i || raddr1_i == '0) begin
         rdata1_o = '0;
      end else if (ex_wreg_i && !flush_i && ex_wd_i == raddr1_i) begin
         rdata1_o = ex_wdata_i;
      end else if (wbWreg_q && wbWd_q == raddr1_i) begin
         rdata1_o = wbWdata_q;
      end
   end

   // Read port 2, same priority as port 1 and fully independent of it.
   always_comb begin
      rdata2_o = regs_q[raddr2_i];
      if (!re2_i || raddr2_i == '0) begin
         rdata2_o = '0;
      end else if (ex_wreg_i && !flush_i && ex_wd_i == raddr2_i) begin
         rdata2_o = ex_wdata_i;
      end else if (wbWreg_q && wbWd_q == raddr2_i) begin
         rdata2_o = wbWdata_q;
      end
   end

   assign wb_wdata_o   = wbWdata_q;
   assign wb_wd_o      = wbWd_q;
   assign wb_wreg_o    = wbWreg_q;
   assign retire_cnt_o = retireCnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//
// Drives wb_regfile with directed scenarios followed by random traffic. A
// behavioural model of the register file (plain array plus a pending-write
// record) produces the expected outputs of every cycle; these are queued and
// compared by an independent monitor on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        flush;
      logic [31:0] exWdata;
      logic [4:0]  exWd;
      logic        exWreg;
      logic        re1;
      logic [4:0]  raddr1;
      logic        re2;
      logic [4:0]  raddr2;
   } stim_t;

   typedef struct {
      int          cycle;
      logic [31:0] rdata1;
      logic [31:0] rdata2;
      logic [31:0] wbWdata;
      logic [4:0]  wbWd;
      logic        wbWreg;
      logic [31:0] retireCnt;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic [31:0] exWdata;
   logic [4:0]  exWd;
   logic        exWreg;
   logic        re1;
   logic [4:0]  raddr1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic [31:0] wbWdata;
   logic [4:0]  wbWd;
   logic        wbWreg;
   logic [31:0] retireCnt;

   int errors = 0;
   int checks = 0;
   int cycleNum = 0;
   exp_t expQ[$];

   // Reference model: architectural registers, one pending write, counter.
   logic [31:0] mRegs [32];
   logic        mPendValid;
   logic [4:0]  mPendIdx;
   logic [31:0] mPendData;
   logic [31:0] mRetired;

   wb_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall),
      .flush_i      (flush),
      .ex_wdata_i   (exWdata),
      .ex_wd_i      (exWd),
      .ex_wreg_i    (exWreg),
      .re1_i        (re1),
      .raddr1_i     (raddr1),
      .re2_i        (re2),
      .raddr2_i     (raddr2),
      .rdata1_o     (rdata1),
      .rdata2_o     (rdata2),
      .wb_wdata_o   (wbWdata),
      .wb_wd_o      (wbWd),
      .wb_wreg_o    (wbWreg),
      .retire_cnt_o (retireCnt)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic modelReset();
      for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
      mPendValid = 1'b0;
      mPendIdx   = 5'd0;
      mPendData  = 32'd0;
      mRetired   = 32'd0;
   endtask

   // What a reader sees: newest live producer first, register zero is zero.
   function automatic logic [31:0] modelRead(input logic en, input logic [4:0] idx);
      if (!en || idx == 5'd0) return 32'd0;
      if (exWreg && !flush && exWd == idx) return exWdata;
      if (mPendValid && mPendIdx == idx) return mPendData;
      return mRegs[idx];
   endfunction

   // Effect of one rising edge on the model, using the inputs held at it.
   task automatic modelEdge();
      if (!rst) return;
      if (mPendValid && !stall && mPendIdx != 5'd0) begin
         mRegs[mPendIdx] = mPendData;
         mRetired = mRetired + 32'd1;
      end
      if (flush) begin
         mPendValid = 1'b0;
         mPendIdx   = 5'd0;
         mPendData  = 32'd0;
      end else if (!stall) begin
         mPendValid = exWreg;
         mPendIdx   = exWd;
         mPendData  = exWdata;
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s.rst = 1'b1; s.stall = 1'b0; s.flush = 1'b0;
      s.exWdata = 32'd0; s.exWd = 5'd0; s.exWreg = 1'b0;
      s.re1 = 1'b1; s.raddr1 = 5'd0; s.re2 = 1'b1; s.raddr2 = 5'd0;
      return s;
   endfunction

   // One cycle: let the edge happen, advance the model, drive the new inputs
   // just after the edge and queue what the outputs must show this cycle.
   task automatic applyStimulus(input stim_t s);
      exp_t e;
      @(posedge clk);
      modelEdge();
      #1;
      rst = s.rst; stall = s.stall; flush = s.flush;
      exWdata = s.exWdata; exWd = s.exWd; exWreg = s.exWreg;
      re1 = s.re1; raddr1 = s.raddr1; re2 = s.re2; raddr2 = s.raddr2;
      if (!rst) modelReset();
      cycleNum++;
      e.cycle     = cycleNum;
      e.rdata1    = modelRead(re1, raddr1);
      e.rdata2    = modelRead(re2, raddr2);
      e.wbWdata   = mPendData;
      e.wbWd      = mPendIdx;
      e.wbWreg    = mPendValid;
      e.retireCnt = mRetired;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string name, input int cyc,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         exp_t e;
         e = expQ.pop_front();
         checkOutput("rdata1",     e.cycle, rdata1,         e.rdata1);
         checkOutput("rdata2",     e.cycle, rdata2,         e.rdata2);
         checkOutput("wb_wdata",   e.cycle, wbWdata,        e.wbWdata);
         checkOutput("wb_wd",      e.cycle, {27'd0, wbWd},  {27'd0, e.wbWd});
         checkOutput("wb_wreg",    e.cycle, {31'd0, wbWreg}, {31'd0, e.wbWreg});
         checkOutput("retire_cnt", e.cycle, retireCnt,      e.retireCnt);
      end
   end

   initial begin
      stim_t s;
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      exWdata = 32'd0; exWd = 5'd0; exWreg = 1'b0;
      re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
      modelReset();

      // Reset, then read an untouched register.
      s = idle(); s.rst = 1'b0; s.raddr1 = 5'd5; applyStimulus(s);
      s = idle(); s.raddr1 = 5'd5; applyStimulus(s);

      // Basic write of register 3, then read it from WB and from the array.
      s = idle(); s.exWd = 5'd3; s.exWdata = 32'h12345678; s.exWreg = 1'b1;
      s.raddr1 = 5'd3; applyStimulus(s);
      s = idle(); s.raddr1 = 5'd3; applyStimulus(s);
      s = idle(); s.raddr1 = 5'd3; s.raddr2 = 5'd3; applyStimulus(s);

      // Forwarding priority on register 7: array=1, WB=2, EX=3.
      s = idle(); s.exWd = 5'd7; s.exWdata = 32'h1; s.exWreg = 1'b1; applyStimulus(s);
      s = idle(); applyStimulus(s);
      s = idle(); s.exWd = 5'd7; s.exWdata = 32'h2; s.exWreg = 1'b1; s.raddr1 = 5'd7;
      applyStimulus(s);
      s = idle(); s.exWd = 5'd7; s.exWdata = 32'h3; s.exWreg = 1'b1; s.stall = 1'b1;
      s.raddr1 = 5'd7; s.raddr2 = 5'd7; applyStimulus(s);
      s = idle(); s.exWd = 5'd7; s.exWdata = 32'h3; s.raddr1 = 5'd7; applyStimulus(s);
      s = idle(); s.raddr1 = 5'd7; applyStimulus(s);

      // Writes to register zero are dropped.
      s = idle(); s.exWd = 5'd0; s.exWdata = 32'hFFFFFFFF; s.exWreg = 1'b1; applyStimulus(s);
      s = idle(); applyStimulus(s);
      s = idle(); applyStimulus(s);

      // Stall for three cycles, then release with a flush on the same edge.
      s = idle(); s.exWd = 5'd4; s.exWdata = 32'hAA; s.exWreg = 1'b1; applyStimulus(s);
      for (int i = 0; i < 3; i++) begin
         s = idle(); s.stall = 1'b1; s.exWd = 5'd9; s.exWdata = 32'hBB; s.exWreg = 1'b1;
         s.raddr1 = 5'd4; s.raddr2 = 5'd9; applyStimulus(s);
      end
      s = idle(); s.flush = 1'b1; s.exWd = 5'd9; s.exWdata = 32'hBB; s.exWreg = 1'b1;
      s.raddr1 = 5'd4; s.raddr2 = 5'd9; applyStimulus(s);
      s = idle(); s.raddr1 = 5'd4; s.raddr2 = 5'd9; applyStimulus(s);
      s = idle(); s.raddr1 = 5'd4; s.raddr2 = 5'd9; applyStimulus(s);

      // Asynchronous reset while WB holds a write to register 6.
      s = idle(); s.exWd = 5'd6; s.exWdata = 32'h55; s.exWreg = 1'b1; applyStimulus(s);
      s = idle(); s.rst = 1'b0; s.raddr1 = 5'd6; s.raddr2 = 5'd4; applyStimulus(s);
      s = idle(); s.rst = 1'b0; s.raddr1 = 5'd6; applyStimulus(s);
      s = idle(); s.raddr1 = 5'd6; s.raddr2 = 5'd4; applyStimulus(s);
      s = idle(); s.raddr1 = 5'd6; applyStimulus(s);

      // Random traffic over a small index range so forwarding hits often.
      for (int i = 0; i < 600; i++) begin
         s.rst     = ($urandom_range(0, 99) != 0);
         s.stall   = ($urandom_range(0, 3) == 0);
         s.flush   = ($urandom_range(0, 9) == 0);
         s.exWdata = $urandom;
         s.exWd    = 5'($urandom_range(0, 7));
         s.exWreg  = ($urandom_range(0, 3) != 0);
         s.re1     = ($urandom_range(0, 9) != 0);
         s.raddr1  = 5'($urandom_range(0, 7));
         s.re2     = ($urandom_range(0, 9) != 0);
         s.raddr2  = 5'($urandom_range(0, 7));
         applyStimulus(s);
      end

      // Drain: every queued expectation must have been consumed.
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expectations expected 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
